program_counter_stack: RTL and testbench
========================================

// Module: program_counter_stack
// PURPOSE
//  Parametrised program counter for the processor control path; successor to the
//  plain 7-bit incrementing counter. Adds absolute jump, signed relative branch,
//  and subroutine call/return with an internal return-address stack.
//  Sits between the control FSM (drives Enable/Op) and the instruction memory address.
// PARAMETERS
//  WIDTH      7    Counter / address width in bits (2..16)
//  OFF_W      5    Width of signed branch offset (2..WIDTH)
//  DEPTH      4    Return-address stack entries (1..16)
//  RESET_VEC  0    Counter value after reset or PC_Clr
// PORTS
//  Clock        in   1        rising-edge clock
//  Reset_n      in   1        asynchronous active-low reset
//  PC_Clr       in   1        synchronous clear, highest synchronous priority
//  Enable       in   1        1 = execute Op this cycle, 0 = hold all state
//  Op           in   3        000 INC, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101-111 reserved
//  Target       in   WIDTH    absolute address for JUMP/CALL
//  Offset       in   OFF_W    two's-complement offset for BRANCH
//  Counter      out  WIDTH    current program counter (registered)
//  Stack_Empty  out  1        stack pointer == 0
//  Stack_Full   out  1        stack pointer == DEPTH
//  Error        out  1        sticky fault flag
// BEHAVIOUR
//  - Reset_n=0 (async, any time): Counter=RESET_VEC, sp=0, Stack_Empty=1, Stack_Full=0,
//    Error=0; stack contents don't-care. Release takes effect at the next rising edge.
//  - Priority per edge: PC_Clr > Enable=0 (hold) > Op. PC_Clr gives the same state as
//    reset, regardless of Enable/Op.
//  - All updates are visible one cycle after the sampling edge; no combinational
//    path from inputs to outputs. Flags derive from registered sp.
//  - INC: Counter <= Counter+1, wrapping 2^WIDTH-1 -> 0 silently (no Error).
//  - JUMP: Counter <= Target.
//  - BRANCH: Counter <= (Counter + sign_ext(Offset)) mod 2^WIDTH; wraps both directions, no Error.
//  - CALL, not full: stack[sp] <= Counter+1 (mod 2^WIDTH), sp <= sp+1, Counter <= Target.
//  - CALL, full: no push, Counter holds, Error <= 1.
//  - RET, not empty: Counter <= stack[sp-1], sp <= sp-1.
//  - RET, empty: Counter holds, sp stays 0, Error <= 1.
//  - Reserved Op with Enable=1: Counter and stack hold, Error <= 1.
//  - Error is sticky and clears only on Reset_n or PC_Clr. Operation continues normally after Error.
//  - Enable=0: Counter, sp, stack and Error are unchanged; Op/Target/Offset are ignored.
//  - Stack is LIFO, one push or pop per cycle max; no simultaneous push+pop is possible.
//  - X on Op/Target/Offset while Enable=0 must not corrupt state.
// TESTING (WIDTH=7, OFF_W=5, DEPTH=4, RESET_VEC=0)
//  1. Reset_n=0 mid-count (Counter=0x25), asserted between edges -> Counter=0 immediately;
//     Empty=1, Error=0; after release, 3 cycles INC -> 1,2,3.
//  2. Set Counter=0x7E, then INC x3 -> 0x7F, 0x00, 0x01 with Error=0.
//     Then Enable=0 for 2 cycles -> holds 0x01.
//  3. At Counter=0x10: BRANCH Offset=5'b11101 (-3) -> 0x0D.
//     At Counter=0x02: BRANCH -3 -> 0x7F. BRANCH +15 from 0x7F -> 0x0E.
//  4. At Counter=0x05: CALL Target=0x40 -> Counter=0x40, Empty=0.
//     RET -> Counter=0x06, Empty=1, Error=0.
//  5. Four nested CALLs (Targets 0x10, 0x20, 0x30, 0x40) -> Full=1.
//     5th CALL -> Counter holds at 0x40, Error=1.
//     Four RETs return 0x31, 0x21, 0x11, then caller+1 -> Empty=1.
//  6. RET when empty -> Counter holds, Error=1. Op=3'b110 -> hold, Error stays 1.
//     PC_Clr=1 with Enable=1 Op=JUMP -> Counter=0, Error=0, Empty=1.

Source files
------------

// File: rtl/program_counter_stack.sv
// program_counter_stack: program counter with jump, relative branch and call/return stack
module program_counter_stack #(
  parameter int                 WIDTH     = 7,
  parameter int                 OFF_W     = 5,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VEC = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pc_clr_i,
  input  logic             enable_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic [OFF_W-1:0] offset_i,
  output logic [WIDTH-1:0] counter_o,
  output logic             stack_empty_o,
  output logic             stack_full_o,
  output logic             error_o
);
  localparam int SP_W = $clog2(DEPTH + 1);
  localparam logic [2:0] OP_INC    = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             error_q, error_d;
  logic             push;
  logic             empty, full;
  logic [WIDTH-1:0] stack_q [2**SP_W];
  assign empty         = sp_q == '0;
  assign full          = sp_q == SP_W'(DEPTH);
  assign counter_o     = counter_q;
  assign stack_empty_o = empty;
  assign stack_full_o  = full;
  assign error_o       = error_q;
  // Next-state selection: clear beats hold, hold beats the opcode
  always_comb begin
    counter_d = counter_q;
    sp_d      = sp_q;
    error_d   = error_q;
    push      = 1'b0;
    if (pc_clr_i) begin
      counter_d = RESET_VEC;
      sp_d      = '0;
      error_d   = 1'b0;
    end else if (enable_i) begin
      case (op_i)
        OP_INC:    counter_d = counter_q + WIDTH'(1);
        OP_JUMP:   counter_d = target_i;
        OP_BRANCH: counter_d = counter_q + WIDTH'($signed(offset_i));
        OP_CALL: begin
          if (full) error_d = 1'b1;
          else begin
            push      = 1'b1;
            sp_d      = sp_q + SP_W'(1);
            counter_d = target_i;
          end
        end
        OP_RET: begin
          if (empty) error_d = 1'b1;
          else begin
            sp_d      = sp_q - SP_W'(1);
            counter_d = stack_q[sp_q - SP_W'(1)];
          end
        end
        default:   error_d = 1'b1;
      endcase
    end
  end
  // Control state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      counter_q <= RESET_VEC;
      sp_q      <= '0;
      error_q   <= 1'b0;
    end else begin
      counter_q <= counter_d;
      sp_q      <= sp_d;
      error_q   <= error_d;
    end
  end
  // Return-address storage; contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    if (push) stack_q[sp_q] <= counter_q + WIDTH'(1);
  end
endmodule

// File: tb/tb_program_counter_stack.sv
// tb_program_counter_stack: directed self-checking bench for program_counter_stack
module tb_program_counter_stack;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       pc_clr;
  logic       enable;
  logic [2:0] op;
  logic [6:0] target;
  logic [4:0] offset;
  logic [6:0] counter;
  logic       empty, full, error;
  int n_checks = 0;
  int n_fail = 0;

  program_counter_stack #(.WIDTH(7), .OFF_W(5), .DEPTH(4), .RESET_VEC(7'h00)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pc_clr_i(pc_clr), .enable_i(enable), .op_i(op),
    .target_i(target), .offset_i(offset), .counter_o(counter),
    .stack_empty_o(empty), .stack_full_o(full), .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic [2:0] o, input logic [6:0] t, input logic [4:0] f);
    enable = en; op = o; target = t; offset = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 3'd1, 7'h25, 5'd0);
    n_checks++; if (counter !== 7'h25) begin n_fail++; $display("FAIL rst_pre got %h exp 25", counter); end
    enable = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (counter !== 7'h00) begin n_fail++; $display("FAIL rst_async got %h exp 00", counter); end
    n_checks++; if ({empty, full, error} !== 3'b100) begin n_fail++; $display("FAIL rst_flags got %b exp 100", {empty, full, error}); end
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 3'd0, 7'h00, 5'd0);
      n_checks++; if (counter !== 7'(i)) begin n_fail++; $display("FAIL rst_inc%0d got %h exp %h", i, counter, 7'(i)); end
    end
  endtask

  task automatic test_inc_wrap;
    logic [6:0] exp_v [3];
    exp_v[0] = 7'h7F; exp_v[1] = 7'h00; exp_v[2] = 7'h01;
    drive(1'b1, 3'd1, 7'h7E, 5'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, 7'h00, 5'd0);
      n_checks++; if (counter !== exp_v[i] || error !== 1'b0) begin n_fail++; $display("FAIL wrap%0d got %h/%b exp %h/0", i, counter, error, exp_v[i]); end
    end
    drive(1'b0, 3'd0, 7'h00, 5'd0);
    drive(1'b0, 3'bxxx, 7'hxx, 5'bxxxxx);
    n_checks++; if (counter !== 7'h01 || error !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL hold got %h/%b/%b exp 01/0/1", counter, error, empty); end
  endtask

  task automatic test_branch;
    drive(1'b1, 3'd1, 7'h10, 5'd0);
    drive(1'b1, 3'd2, 7'h00, 5'b11101);
    n_checks++; if (counter !== 7'h0D) begin n_fail++; $display("FAIL br_neg got %h exp 0d", counter); end
    drive(1'b1, 3'd1, 7'h02, 5'd0);
    drive(1'b1, 3'd2, 7'h00, 5'b11101);
    n_checks++; if (counter !== 7'h7F) begin n_fail++; $display("FAIL br_wrapdn got %h exp 7f", counter); end
    drive(1'b1, 3'd2, 7'h00, 5'b01111);
    n_checks++; if (counter !== 7'h0E || error !== 1'b0) begin n_fail++; $display("FAIL br_wrapup got %h/%b exp 0e/0", counter, error); end
  endtask

  task automatic test_call_ret;
    drive(1'b1, 3'd1, 7'h05, 5'd0);
    drive(1'b1, 3'd3, 7'h40, 5'd0);
    n_checks++; if (counter !== 7'h40 || empty !== 1'b0) begin n_fail++; $display("FAIL call got %h/%b exp 40/0", counter, empty); end
    drive(1'b1, 3'd4, 7'h00, 5'd0);
    n_checks++; if (counter !== 7'h06 || empty !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL ret got %h/%b/%b exp 06/1/0", counter, empty, error); end
  endtask

  task automatic test_nested;
    logic [6:0] ret_v [4];
    ret_v[0] = 7'h31; ret_v[1] = 7'h21; ret_v[2] = 7'h11; ret_v[3] = 7'h51;
    drive(1'b1, 3'd1, 7'h50, 5'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 3'd3, 7'(i * 16), 5'd0);
      n_checks++; if (counter !== 7'(i * 16) || full !== (i == 4)) begin n_fail++; $display("FAIL ncall%0d got %h/%b exp %h/%b", i, counter, full, 7'(i * 16), i == 4); end
    end
    drive(1'b1, 3'd3, 7'h60, 5'd0);
    n_checks++; if (counter !== 7'h40 || error !== 1'b1 || full !== 1'b1) begin n_fail++; $display("FAIL overflow got %h/%b/%b exp 40/1/1", counter, error, full); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd4, 7'h00, 5'd0);
      n_checks++; if (counter !== ret_v[i] || full !== 1'b0 || empty !== (i == 3)) begin n_fail++; $display("FAIL nret%0d got %h/%b exp %h/%b", i, counter, empty, ret_v[i], i == 3); end
    end
  endtask

  task automatic test_errors;
    pc_clr = 1'b1;
    drive(1'b0, 3'd0, 7'h00, 5'd0);
    pc_clr = 1'b0;
    n_checks++; if (counter !== 7'h00 || error !== 1'b0) begin n_fail++; $display("FAIL clr_hold got %h/%b exp 00/0", counter, error); end
    drive(1'b1, 3'd1, 7'h33, 5'd0);
    drive(1'b1, 3'd4, 7'h00, 5'd0);
    n_checks++; if (counter !== 7'h33 || error !== 1'b1 || empty !== 1'b1) begin n_fail++; $display("FAIL underflow got %h/%b/%b exp 33/1/1", counter, error, empty); end
    drive(1'b1, 3'b110, 7'h12, 5'd1);
    n_checks++; if (counter !== 7'h33 || error !== 1'b1) begin n_fail++; $display("FAIL reserved got %h/%b exp 33/1", counter, error); end
    drive(1'b1, 3'd0, 7'h00, 5'd0);
    n_checks++; if (counter !== 7'h34 || error !== 1'b1) begin n_fail++; $display("FAIL sticky got %h/%b exp 34/1", counter, error); end
    drive(1'b1, 3'd3, 7'h70, 5'd0);
    pc_clr = 1'b1;
    drive(1'b1, 3'd1, 7'h55, 5'd0);
    pc_clr = 1'b0;
    n_checks++; if (counter !== 7'h00 || error !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL clr got %h/%b/%b exp 00/0/1", counter, error, empty); end
  endtask

  task automatic test_reserved_clean;
    drive(1'b1, 3'b101, 7'h00, 5'd0);
    n_checks++; if (counter !== 7'h00 || error !== 1'b1) begin n_fail++; $display("FAIL res101 got %h/%b exp 00/1", counter, error); end
    drive(1'b0, 3'b111, 7'h00, 5'd0);
    n_checks++; if (error !== 1'b1 || counter !== 7'h00) begin n_fail++; $display("FAIL res_hold got %h/%b exp 00/1", counter, error); end
  endtask

  initial begin
    rst_n = 1'b0; pc_clr = 1'b0; enable = 1'b0; op = 3'd0; target = '0; offset = '0;
    #1;
    n_checks++; if (counter !== 7'h00 || {empty, full, error} !== 3'b100) begin n_fail++; $display("FAIL init got %h/%b exp 00/100", counter, {empty, full, error}); end
    @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_inc_wrap;
    test_branch;
    test_call_ret;
    test_nested;
    test_errors;
    test_reserved_clean;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
